snake_path_engine: RTL and testbench

- Parametrised snake-body tracker for the VGA snake game.
- Keeps head and tail coordinates plus a ring buffer of turn points, one entry per direction change.
- Advances head and tail on a per-frame step pulse, detects wall collisions, and supports growth.
- Direction commands come from the UART key decoder; the pixel renderer reads turn points through a registered read port.

---
 rtl/snake_path_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_snake_path_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_path_engine.sv
// Snake body tracker: head/tail coordinates, a ring buffer of turn points and a registered read port.
// Optional feature: define SNAKE_WRAP_EN to make the playfield walls wrap instead of killing the snake.
module snake_path_engine #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int DEPTH     = 64,
    parameter int FIELD_W   = 640,
    parameter int FIELD_H   = 480,
    parameter int INIT_X    = 300,
    parameter int INIT_Y    = 200,
    parameter int INIT_LEN  = 200,
    parameter int GROW_STEP = 16,
    parameter int GROW_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         step,
    input  logic                         grow,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd_dir,
    output logic                         cmd_ready,
    output logic [X_W-1:0]               head_x,
    output logic [Y_W-1:0]               head_y,
    output logic [X_W-1:0]               tail_x,
    output logic [Y_W-1:0]               tail_y,
    output logic [1:0]                   head_dir,
    output logic [1:0]                   tail_dir,
    output logic [$clog2(DEPTH+1)-1:0]   turn_cnt,
    output logic                         full,
    output logic                         running,
    output logic                         dead,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [Y_W+X_W+1:0]           rd_data,
    output logic                         rd_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int E_W   = Y_W + X_W + 2;

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [X_W-1:0]    X_LAST      = X_W'(FIELD_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST      = Y_W'(FIELD_H - 1);
    localparam logic [X_W-1:0]    X_ONE       = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE       = Y_W'(1);
    localparam logic [X_W-1:0]    X_INIT      = X_W'(INIT_X);
    localparam logic [X_W-1:0]    X_TAIL_INIT = X_W'(INIT_X - INIT_LEN);
    localparam logic [Y_W-1:0]    Y_INIT      = Y_W'(INIT_Y);
    localparam logic [GROW_W:0]   G_MAX       = {1'b0, {GROW_W{1'b1}}};
    localparam logic [GROW_W:0]   G_ADD       = (GROW_W+1)'(GROW_STEP);
    localparam logic [GROW_W:0]   G_ONE       = (GROW_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W:0]    DEPTH_E     = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [1:0] d);
        logic [X_W-1:0] r;
        r = x;
        if (d == DIR_RIGHT)
            r = (WRAP && x == X_LAST) ? '0 : x + X_ONE;
        else if (d == DIR_LEFT)
            r = (WRAP && x == '0) ? X_LAST : x - X_ONE;
        return r;
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [1:0] d);
        logic [Y_W-1:0] r;
        r = y;
        if (d == DIR_DOWN)
            r = (WRAP && y == Y_LAST) ? '0 : y + Y_ONE;
        else if (d == DIR_UP)
            r = (WRAP && y == '0) ? Y_LAST : y - Y_ONE;
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    logic [1:0]        state;
    logic [E_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [GROW_W-1:0] grow_cnt;

    logic              restart;
    logic              turn;
    logic              at_wall;
    logic              hit;
    logic              advance;
    logic              push;
    logic              pop;
    logic              pop_match;
    logic              hold;
    logic [1:0]        eff_hdir;
    logic [1:0]        eff_tdir;
    logic [E_W-1:0]    oldest;
    logic [X_W-1:0]    hx_next;
    logic [Y_W-1:0]    hy_next;
    logic [X_W-1:0]    tx_next;
    logic [Y_W-1:0]    ty_next;
    logic [GROW_W:0]   g_sum;
    logic [GROW_W-1:0] g_next;
    logic [PTR_W:0]    rd_sum;
    logic              rd_hit;

    assign running   = (state == ST_RUN);
    assign dead      = (state == ST_DEAD);
    assign full      = (turn_cnt == CNT_FULL);
    assign cmd_ready = running & ~full;

    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        restart  = dead & start;
        turn     = cmd_valid & cmd_ready & (cmd_dir != head_dir) & (cmd_dir != (head_dir ^ 2'b01));
        eff_hdir = turn ? cmd_dir : head_dir;
        hx_next  = step_x(head_x, eff_hdir);
        hy_next  = step_y(head_y, eff_hdir);

        // A wall is hit when the one-step move would leave the field, including 0-1 underflow.
        at_wall  = ((eff_hdir == DIR_RIGHT) && (head_x == X_LAST)) ||
                   ((eff_hdir == DIR_LEFT)  && (head_x == '0))     ||
                   ((eff_hdir == DIR_UP)    && (head_y == '0))     ||
                   ((eff_hdir == DIR_DOWN)  && (head_y == Y_LAST));
        hit      = !WRAP && running && step && at_wall;
        advance  = running & step & ~hit;

        oldest    = mem[rd_ptr];
        pop_match = (turn_cnt != '0) &&
                    (oldest[E_W-1:X_W+2] == tail_y) && (oldest[X_W+1:2] == tail_x);
        eff_tdir  = pop_match ? oldest[1:0] : tail_dir;
        tx_next   = step_x(tail_x, eff_tdir);
        ty_next   = step_y(tail_y, eff_tdir);

        push = turn & ~hit;
        pop  = advance & pop_match;
        hold = (grow_cnt != '0);

        g_sum  = {1'b0, grow_cnt} + ((running & grow) ? G_ADD : '0) - ((advance & hold) ? G_ONE : '0);
        g_next = (g_sum > G_MAX) ? G_MAX[GROW_W-1:0] : g_sum[GROW_W-1:0];

        rd_sum = {1'b0, rd_ptr} + {1'b0, rd_idx};
        if (rd_sum >= DEPTH_E)
            rd_sum = rd_sum - DEPTH_E;
        rd_hit = (CNT_W'(rd_idx) < turn_cnt);
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state    <= rst ? ST_IDLE : ST_RUN;
            head_x   <= X_INIT;
            head_y   <= Y_INIT;
            tail_x   <= X_TAIL_INIT;
            tail_y   <= Y_INIT;
            head_dir <= DIR_RIGHT;
            tail_dir <= DIR_RIGHT;
            turn_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            grow_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) && start)
                state <= ST_RUN;
            if (hit)
                state <= ST_DEAD;
            if (running)
                grow_cnt <= g_next;
            if (advance) begin
                head_x <= hx_next;
                head_y <= hy_next;
                if (!hold) begin
                    tail_x <= tx_next;
                    tail_y <= ty_next;
                end
            end
            if (push) begin
                wr_ptr   <= ptr_inc(wr_ptr);
                head_dir <= cmd_dir;
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                tail_dir <= eff_tdir;
            end
            case ({push, pop})
                2'b10:   turn_cnt <= turn_cnt + CNT_ONE;
                2'b01:   turn_cnt <= turn_cnt - CNT_ONE;
                default: turn_cnt <= turn_cnt;
            endcase
        end
    end

    // NOTE: the turn-point storage has no reset; entries are only observed while covered by turn_cnt.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {head_y, head_x, cmd_dir};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            rd_data  <= rd_hit ? mem[rd_sum[PTR_W-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_snake_path_engine.sv
// Directed self-checking bench for snake_path_engine with default parameters.
// Expectations follow SNAKE_WRAP_EN when the bench is built with it defined.
module tb_snake_path_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step;
    logic        grow;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [9:0]  head_x;
    logic [9:0]  head_y;
    logic [9:0]  tail_x;
    logic [9:0]  tail_y;
    logic [1:0]  head_dir;
    logic [1:0]  tail_dir;
    logic [6:0]  turn_cnt;
    logic        full;
    logic        running;
    logic        dead;
    logic [5:0]  rd_idx;
    logic [21:0] rd_data;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    snake_path_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .grow      (grow),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .head_x    (head_x),
        .head_y    (head_y),
        .tail_x    (tail_x),
        .tail_y    (tail_y),
        .head_dir  (head_dir),
        .tail_dir  (tail_dir),
        .turn_cnt  (turn_cnt),
        .full      (full),
        .running   (running),
        .dead      (dead),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        @(negedge clk);
        grow = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [1:0] d);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic read_entry(input logic [5:0] idx);
        rd_idx = idx;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; grow = 1'b0;
        cmd_valid = 1'b0; cmd_dir = 2'b00; rd_idx = '0;
        @(negedge clk);
        @(negedge clk);

        check("rst_head_x", head_x, 300);
        check("rst_head_y", head_y, 200);
        check("rst_tail_x", tail_x, 100);
        check("rst_tail_y", tail_y, 200);
        check("rst_dirs", {head_dir, tail_dir}, 0);
        check("rst_turn_cnt", turn_cnt, 0);
        check("rst_running", running, 0);
        check("rst_dead", dead, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        rst = 1'b0;

        // Ignored outside RUN
        steps(2);
        check("idle_step_ignored", head_x, 300);

        pulse_start();
        check("start_running", running, 1);
        check("start_cmd_ready", cmd_ready, 1);

        steps(10);
        check("s10_head_x", head_x, 310);
        check("s10_head_y", head_y, 200);
        check("s10_tail_x", tail_x, 110);
        check("s10_turn_cnt", turn_cnt, 0);
        check("s10_running", running, 1);

        send_cmd(2'b10);
        check("up_turn_cnt", turn_cnt, 1);
        check("up_head_dir", head_dir, 2);
        check("up_head_still", head_x, 310);

        steps(5);
        check("up5_head_x", head_x, 310);
        check("up5_head_y", head_y, 195);
        read_entry(0);
        check("rd0_data", rd_data, {10'd200, 10'd310, 2'b10});
        check("rd0_valid", rd_valid, 1);
        read_entry(1);
        check("rd1_valid", rd_valid, 0);
        check("rd1_data", rd_data, 0);

        steps(190);
        check("up195_head_y", head_y, 5);
        check("up195_tail_x", tail_x, 305);
        send_cmd(2'b00);
        check("right_turn_cnt", turn_cnt, 2);

        // Tail reaches (310,200) after 5 steps, pops and turns up on the 6th
        steps(10);
        check("pop_head_x", head_x, 320);
        check("pop_head_y", head_y, 5);
        check("pop_tail_x", tail_x, 310);
        check("pop_tail_y", tail_y, 195);
        check("pop_tail_dir", tail_dir, 2);
        check("pop_turn_cnt", turn_cnt, 1);
        read_entry(0);
        check("pop_rd0_data", rd_data, {10'd5, 10'd310, 2'b00});

        check("opp_cmd_ready", cmd_ready, 1);
        send_cmd(2'b01);
        check("opp_turn_cnt", turn_cnt, 1);
        check("opp_head_dir", head_dir, 0);
        send_cmd(2'b00);
        check("same_turn_cnt", turn_cnt, 1);

        // Fill the buffer at (300,200) with alternating up/right turns
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++)
            send_cmd((i % 2 == 0) ? 2'b10 : 2'b00);
        check("fill_full", full, 1);
        check("fill_cmd_ready", cmd_ready, 0);
        check("fill_turn_cnt", turn_cnt, 64);
        check("fill_head_dir", head_dir, 0);
        send_cmd(2'b10);
        check("full_cmd_blocked", turn_cnt, 64);
        check("full_head_dir", head_dir, 0);
        read_entry(63);
        check("full_rd63_data", rd_data, {10'd200, 10'd300, 2'b00});
        check("full_rd63_valid", rd_valid, 1);

        steps(200);
        check("fill_tail_at_pt", tail_x, 300);
        check("fill_still_full", full, 1);
        steps(1);
        check("fill_pop_cnt", turn_cnt, 63);
        check("fill_pop_ready", cmd_ready, 1);
        check("fill_pop_tail_y", tail_y, 199);
        check("fill_pop_tail_dir", tail_dir, 2);
        check("fill_pop_head_x", head_x, 501);
        read_entry(63);
        check("pop_rd63_valid", rd_valid, 0);
        check("pop_rd63_data", rd_data, 0);

        // Growth holds the tail for GROW_STEP steps
        do_reset();
        pulse_start();
        pulse_grow();
        steps(16);
        check("grow_head_x", head_x, 316);
        check("grow_tail_held", tail_x, 100);
        steps(1);
        check("grow_head_x17", head_x, 317);
        check("grow_tail_moves", tail_x, 101);

        // Right wall
        do_reset();
        pulse_start();
        steps(339);
        check("wall_head_x", head_x, 639);
        check("wall_tail_x", tail_x, 439);
        steps(1);
`ifdef SNAKE_WRAP_EN
        check("wrap_head_x", head_x, 0);
        check("wrap_dead", dead, 0);
        check("wrap_running", running, 1);
`else
        check("wall_dead", dead, 1);
        check("wall_head_frozen", head_x, 639);
        check("wall_tail_frozen", tail_x, 439);
        check("wall_running", running, 0);
        check("wall_cmd_ready", cmd_ready, 0);
        steps(1);
        check("dead_step_ignored", head_x, 639);
        pulse_start();
        check("restart_head_x", head_x, 300);
        check("restart_tail_x", tail_x, 100);
        check("restart_running", running, 1);
        check("restart_dead", dead, 0);
`endif

        // Top wall, 0-1 underflow
        do_reset();
        pulse_start();
        send_cmd(2'b10);
        steps(200);
        check("top_head_y", head_y, 0);
        steps(1);
`ifdef SNAKE_WRAP_EN
        check("wrap_head_y", head_y, 479);
        check("wrap_top_dead", dead, 0);
`else
        check("top_dead", dead, 1);
        check("top_head_frozen", head_y, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
